ball_controller: RTL

Sequencer for the ball datapath: decides each frame which movement code the ball-position register receives, how many single-pixel steps it takes, and when it is re-centred. Reflects the ball off the top/bottom walls and both paddles, detects goals, keeps per-player scores and runs serve/game-over sequencing. Sits between the VGA frame timing and the ball-position block; `cw_ballMovement` drives that block directly.

---
 rtl/ball_controller.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ball_controller.sv
// ball_controller: frame-driven ball sequencer handling serve, wall/paddle bounces, goals, scores and game over.
module ball_controller #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int BALL_R        = 4,
    parameter int PADDLE_L_X    = 20,
    parameter int PADDLE_R_X    = 619,
    parameter int PADDLE_HALF_H = 32,
    parameter int SPEED         = 2,
    parameter int SERVE_FRAMES  = 60,
    parameter int MAX_SCORE     = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] ball_center_x,
    input  logic [9:0] ball_center_y,
    input  logic [9:0] paddle_left_y,
    input  logic [9:0] paddle_right_y,
    output logic [3:0] cw_ballMovement,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       goal_left,
    output logic       goal_right,
    output logic       game_over
);
    typedef enum logic [2:0] {CENTER, SERVE, IDLE, CHECK, MOVE, OVER} state_t;
    state_t state_q, state_d;
    logic dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
    logic [7:0] serve_q, serve_d;
    logic [3:0] step_q, step_d;
    logic goal_l_q, goal_l_d, goal_r_q, goal_r_d, over_q, over_d;
    logic [3:0] code_q, code_d;
    logic [10:0] bx, by, pl, pr;
    logic hit_goal_r, hit_goal_l, hit_top, hit_bot, hit_pl, hit_pr;
    assign bx = {1'b0, ball_center_x};
    assign by = {1'b0, ball_center_y};
    assign pl = {1'b0, paddle_left_y};
    assign pr = {1'b0, paddle_right_y};
    // Subtractions are moved to the other side so 11-bit compares never wrap.
    assign hit_goal_r = bx <= 11'(BALL_R);
    assign hit_goal_l = bx >= 11'(SCREEN_W - 1 - BALL_R);
    assign hit_top    = by <= 11'(BALL_R);
    assign hit_bot    = by >= 11'(SCREEN_H - 1 - BALL_R);
    assign hit_pl = !dir_x_q && bx <= 11'(PADDLE_L_X + BALL_R) && bx + 11'd8 > 11'(PADDLE_L_X + BALL_R)
                    && by <= pl + 11'(PADDLE_HALF_H) && pl <= by + 11'(PADDLE_HALF_H);
    assign hit_pr = dir_x_q && bx + 11'(BALL_R) >= 11'(PADDLE_R_X) && bx + 11'(BALL_R) < 11'(PADDLE_R_X + 8)
                    && by <= pr + 11'(PADDLE_HALF_H) && pr <= by + 11'(PADDLE_HALF_H);
    always_comb begin
        state_d   = state_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        serve_d   = serve_q;
        step_d    = step_q;
        goal_l_d  = 1'b0;
        goal_r_d  = 1'b0;
        case (state_q)
            CENTER: begin
                state_d = SERVE;
                serve_d = '0;
            end
            SERVE: if (frame_tick) begin
                serve_d = serve_q + 8'd1;
                state_d = serve_q == 8'(SERVE_FRAMES - 1) ? IDLE : SERVE;
            end
            IDLE: if (frame_tick) begin
                step_d  = 4'(SPEED);
                state_d = CHECK;
            end
            CHECK: if (hit_goal_r) begin
                score_r_d = score_r_q + 4'(score_r_q != 4'(MAX_SCORE));
                goal_r_d  = 1'b1;
                dir_x_d   = 1'b0;
                state_d   = score_r_d == 4'(MAX_SCORE) ? OVER : CENTER;
            end else if (hit_goal_l) begin
                score_l_d = score_l_q + 4'(score_l_q != 4'(MAX_SCORE));
                goal_l_d  = 1'b1;
                dir_x_d   = 1'b1;
                state_d   = score_l_d == 4'(MAX_SCORE) ? OVER : CENTER;
            end else begin
                dir_y_d = hit_top ? 1'b1 : hit_bot ? 1'b0 : dir_y_q;
                dir_x_d = hit_pl ? 1'b1 : hit_pr ? 1'b0 : dir_x_q;
                state_d = MOVE;
            end
            MOVE: begin
                step_d  = step_q - 4'd1;
                state_d = step_q == 4'd1 ? IDLE : CHECK;
            end
            OVER: state_d = OVER;
            default: state_d = CENTER;
        endcase
        // A restart discards anything the current cycle decided, directions included.
        if (start) begin
            state_d   = CENTER;
            dir_x_d   = dir_x_q;
            dir_y_d   = dir_y_q;
            score_l_d = '0;
            score_r_d = '0;
            goal_l_d  = 1'b0;
            goal_r_d  = 1'b0;
        end
        over_d = state_d == OVER;
        code_d = state_d == CENTER ? 4'b0101 :
                 state_d != MOVE   ? 4'b0000 :
                 dir_x_d ? (dir_y_d ? 4'b0001 : 4'b0100) : (dir_y_d ? 4'b0011 : 4'b0010);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CENTER;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            score_l_q <= '0;
            score_r_q <= '0;
            serve_q   <= '0;
            step_q    <= '0;
            goal_l_q  <= 1'b0;
            goal_r_q  <= 1'b0;
            over_q    <= 1'b0;
            code_q    <= 4'b0101;
        end else begin
            state_q   <= state_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            serve_q   <= serve_d;
            step_q    <= step_d;
            goal_l_q  <= goal_l_d;
            goal_r_q  <= goal_r_d;
            over_q    <= over_d;
            code_q    <= code_d;
        end
    end
    assign cw_ballMovement = code_q;
    assign score_left      = score_l_q;
    assign score_right     = score_r_q;
    assign goal_left       = goal_l_q;
    assign goal_right      = goal_r_q;
    assign game_over       = over_q;
endmodule
